// File: rtl/spi_bus_bridge.sv
// SPI mode-0 target, oversampled on clk, that turns framed host commands into
// single-beat bus reads/writes with a one-deep request queue and reply byte.
module spi_bus_bridge #(
    parameter int ADDR_WIDTH  = 17,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_cs_n,
    input  logic                  spi_sclk,
    input  logic                  spi_rx,
    output logic                  spi_tx,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [7:0]            bus_wr_data,
    input  logic [7:0]            bus_rd_data,
    input  logic                  bus_ack,
    output logic                  cmd_err,
    output logic                  rd_late
);

    typedef enum logic [2:0] {
        ST_CMD,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_DATA,
        ST_REPLY,
        ST_DONE
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] rx_sync_q, rx_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    state_t                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [6:0]             rx_shift_q, rx_shift_d;
    logic [7:0]             tx_shift_q, tx_shift_d;
    logic [3:0]             cmd_nib_q, cmd_nib_d;
    logic [7:0]             addr_hi_q, addr_hi_d;
    logic                   is_read_q, is_read_d;
    logic [ADDR_WIDTH-1:0]  tgt_addr_q, tgt_addr_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   bus_req_q, bus_req_d;
    logic                   bus_we_q, bus_we_d;
    logic [ADDR_WIDTH-1:0]  bus_addr_q, bus_addr_d;
    logic [7:0]             bus_wr_data_q, bus_wr_data_d;
    logic [7:0]             rd_data_q, rd_data_d;
    logic                   rd_valid_q, rd_valid_d;
    logic                   pend_q, pend_d;
    logic                   pend_we_q, pend_we_d;
    logic [ADDR_WIDTH-1:0]  pend_addr_q, pend_addr_d;
    logic [7:0]             pend_data_q, pend_data_d;
    logic                   cmd_err_q, cmd_err_d;
    logic                   rd_late_q, rd_late_d;

    logic                   sclk_s, cs_s, rx_s, sclk_rise, sclk_fall;
    logic [7:0]             rx_byte;
    logic                   issue, iss_we;
    logic [ADDR_WIDTH-1:0]  iss_addr, addr_inc, at_addr;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign rx_s      = rx_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign rx_byte   = {rx_shift_q, rx_s};
    assign addr_inc  = addr_q + ADDR_WIDTH'(1);
    // Command-byte address bits at or above ADDR_WIDTH are dropped by the cast.
    assign at_addr   = ADDR_WIDTH'({cmd_nib_q, addr_hi_q, rx_byte});

    always_comb begin
        sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
        cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        rx_sync_d     = {rx_sync_q[SYNC_STAGES-2:0], spi_rx};
        sclk_prev_d   = sclk_s;
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        cmd_nib_d     = cmd_nib_q;
        addr_hi_d     = addr_hi_q;
        is_read_d     = is_read_q;
        tgt_addr_d    = tgt_addr_q;
        addr_d        = addr_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_wr_data_d = bus_wr_data_q;
        rd_data_d     = rd_data_q;
        rd_valid_d    = rd_valid_q;
        pend_d        = pend_q;
        pend_we_d     = pend_we_q;
        pend_addr_d   = pend_addr_q;
        pend_data_d   = pend_data_q;
        cmd_err_d     = 1'b0;
        rd_late_d     = 1'b0;
        issue         = 1'b0;
        iss_we        = 1'b0;
        iss_addr      = addr_q;

        if (cs_s) begin
            bit_cnt_d  = '0;
            state_d    = ST_CMD;
            tx_shift_d = '0;
        end else if (sclk_rise) begin
            rx_shift_d = rx_byte[6:0];
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                case (state_q)
                    ST_CMD: begin
                        rd_valid_d = 1'b0;
                        cmd_nib_d  = rx_byte[3:0];
                        case (rx_byte[7:4])
                            4'h0: begin is_read_d = 1'b0; state_d = ST_ADDR_HI; end
                            4'h1: begin is_read_d = 1'b1; state_d = ST_ADDR_HI; end
                            4'h2: begin tgt_addr_d = addr_inc; state_d = ST_DATA; end
                            4'h3: begin
                                issue    = 1'b1;
                                iss_addr = addr_inc;
                                state_d  = ST_REPLY;
                            end
                            default: begin cmd_err_d = 1'b1; state_d = ST_DONE; end
                        endcase
                    end
                    ST_ADDR_HI: begin
                        addr_hi_d = rx_byte;
                        state_d   = ST_ADDR_LO;
                    end
                    ST_ADDR_LO: begin
                        if (is_read_q) begin
                            issue    = 1'b1;
                            iss_addr = at_addr;
                            state_d  = ST_REPLY;
                        end else begin
                            tgt_addr_d = at_addr;
                            state_d    = ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        issue    = 1'b1;
                        iss_we   = 1'b1;
                        iss_addr = tgt_addr_q;
                        state_d  = ST_DONE;
                    end
                    default: ;
                endcase
            end
        end else if (sclk_fall) begin
            if (state_q == ST_REPLY) begin
                tx_shift_d = rd_valid_q ? rd_data_q : 8'h00;
                rd_late_d  = ~rd_valid_q;
                rd_valid_d = 1'b0;
                state_d    = ST_DONE;
            end else begin
                tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end
        end

        // An ack always retires the current request first; anything issued in
        // the same cycle waits in the queue and goes out one cycle later.
        if (bus_req_q) begin
            if (bus_ack) begin
                bus_req_d = 1'b0;
                if (!bus_we_q) begin
                    rd_data_d  = bus_rd_data;
                    rd_valid_d = 1'b1;
                end
            end
            if (issue) begin
                pend_d      = 1'b1;
                pend_we_d   = iss_we;
                pend_addr_d = iss_addr;
                pend_data_d = rx_byte;
            end
        end else if (pend_q) begin
            bus_req_d     = 1'b1;
            bus_we_d      = pend_we_q;
            bus_addr_d    = pend_addr_q;
            bus_wr_data_d = pend_data_q;
            pend_d        = issue;
            pend_we_d     = iss_we;
            pend_addr_d   = iss_addr;
            pend_data_d   = rx_byte;
        end else if (issue) begin
            bus_req_d     = 1'b1;
            bus_we_d      = iss_we;
            bus_addr_d    = iss_addr;
            bus_wr_data_d = rx_byte;
        end
        if (issue) addr_d = iss_addr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q   <= '0;
            cs_sync_q     <= '1;
            rx_sync_q     <= '0;
            sclk_prev_q   <= 1'b0;
            state_q       <= ST_CMD;
            bit_cnt_q     <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            cmd_nib_q     <= '0;
            addr_hi_q     <= '0;
            is_read_q     <= 1'b0;
            tgt_addr_q    <= '0;
            addr_q        <= '0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_wr_data_q <= '0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            pend_q        <= 1'b0;
            pend_we_q     <= 1'b0;
            pend_addr_q   <= '0;
            pend_data_q   <= '0;
            cmd_err_q     <= 1'b0;
            rd_late_q     <= 1'b0;
        end else begin
            sclk_sync_q   <= sclk_sync_d;
            cs_sync_q     <= cs_sync_d;
            rx_sync_q     <= rx_sync_d;
            sclk_prev_q   <= sclk_prev_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            cmd_nib_q     <= cmd_nib_d;
            addr_hi_q     <= addr_hi_d;
            is_read_q     <= is_read_d;
            tgt_addr_q    <= tgt_addr_d;
            addr_q        <= addr_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wr_data_q <= bus_wr_data_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            pend_q        <= pend_d;
            pend_we_q     <= pend_we_d;
            pend_addr_q   <= pend_addr_d;
            pend_data_q   <= pend_data_d;
            cmd_err_q     <= cmd_err_d;
            rd_late_q     <= rd_late_d;
        end
    end

    assign spi_tx      = tx_shift_q[7];
    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wr_data = bus_wr_data_q;
    assign cmd_err     = cmd_err_q;
    assign rd_late     = rd_late_q;

endmodule

// File: tb/tb_spi_bus_bridge.sv
// Directed bench for spi_bus_bridge: table of SPI frames with expected bus
// transactions, plus hand sequences for late reads, queueing and reset.
module tb_spi_bus_bridge;

    localparam int AW   = 17;
    localparam int HALF = 8;

    logic          clk, reset, spi_cs_n, spi_sclk, spi_rx, spi_tx;
    logic          bus_req, bus_we, bus_ack, cmd_err, rd_late;
    logic [AW-1:0] bus_addr;
    logic [7:0]    bus_wr_data, bus_rd_data;

    spi_bus_bridge #(.ADDR_WIDTH(AW), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
        .spi_rx(spi_rx), .spi_tx(spi_tx), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
        .bus_ack(bus_ack), .cmd_err(cmd_err), .rd_late(rd_late)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;
    int late_cnt = 0;
    int req_rise = 0;
    logic req_prev = 1'b0;
    logic ack_en = 1'b1;
    int   ack_lat = 2;
    logic          log_we[$];
    logic [AW-1:0] log_addr[$];
    logic [7:0]    log_data[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmd_err === 1'b1) err_cnt++;
        if (rd_late === 1'b1) late_cnt++;
        if (bus_req === 1'b1 && !req_prev) req_rise++;
        req_prev = (bus_req === 1'b1);
    end

    // Bus responder: acks ack_lat cycles after it first sees bus_req.
    initial begin
        bus_ack = 1'b0;
        forever begin
            @(negedge clk);
            bus_ack = 1'b0;
            if (bus_req === 1'b1 && ack_en) begin
                for (int i = 0; i < ack_lat; i++) begin
                    @(negedge clk);
                    check("req_held", bus_req, 1);
                end
                bus_ack = 1'b1;
                log_we.push_back(bus_we);
                log_addr.push_back(bus_addr);
                log_data.push_back(bus_wr_data);
                @(negedge clk);
                bus_ack = 1'b0;
                check("req_drop", bus_req, 0);
            end
        end
    end

    task automatic spi_bit(input logic b, output logic m);
        spi_rx = b;
        repeat (HALF) @(negedge clk);
        m = spi_tx;
        spi_sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        spi_sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] d, output logic [7:0] m);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(d[i], b);
            m[i] = b;
        end
    endtask

    task automatic spi_frame(input logic [31:0] bytes, input int n, output logic [7:0] last);
        logic [7:0] m;
        m = '0;
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < n; k++) spi_byte(bytes[31-8*k -: 8], m);
        last = m;
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_outputs_reset(input string tag);
        check({tag, "_spi_tx"},  spi_tx, 0);
        check({tag, "_bus_req"}, bus_req, 0);
        check({tag, "_bus_we"},  bus_we, 0);
        check({tag, "_bus_addr"}, bus_addr, 0);
        check({tag, "_wr_data"}, bus_wr_data, 0);
        check({tag, "_cmd_err"}, cmd_err, 0);
        check({tag, "_rd_late"}, rd_late, 0);
    endtask

    typedef struct {
        logic [31:0] bytes;
        int          nbytes;
        logic [7:0]  rd_data;
        int          lat;
        int          exp_reqs;
        logic        exp_we;
        logic [AW-1:0] exp_addr;
        logic [7:0]  exp_wdata;
        logic        chk_miso;
        logic [7:0]  exp_miso;
        int          exp_err;
        int          exp_late;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [7:0] miso, b8;
        logic       bt;
        int n0, e0, l0, r0;

        vecs[0] = '{32'h0180005A, 4, 8'h00, 2, 1, 1'b1, 17'h18000, 8'h5A, 1'b0, 8'h00, 0, 0};
        vecs[1] = '{32'h11123400, 4, 8'hC3, 3, 1, 1'b0, 17'h11234, 8'h00, 1'b1, 8'hC3, 0, 0};
        vecs[2] = '{32'h01FFFF11, 4, 8'h00, 1, 1, 1'b1, 17'h1FFFF, 8'h11, 1'b0, 8'h00, 0, 0};
        vecs[3] = '{32'h20770000, 2, 8'h00, 2, 1, 1'b1, 17'h00000, 8'h77, 1'b0, 8'h00, 0, 0};
        vecs[4] = '{32'h70123456, 4, 8'h00, 2, 0, 1'b0, 17'h00000, 8'h00, 1'b0, 8'h00, 1, 0};
        vecs[5] = '{32'h30000000, 2, 8'hA5, 2, 1, 1'b0, 17'h00001, 8'h00, 1'b1, 8'hA5, 0, 0};
        vecs[6] = '{32'h0FABCD3C, 4, 8'h00, 1, 1, 1'b1, 17'h1ABCD, 8'h3C, 1'b0, 8'h00, 0, 0};
        vecs[7] = '{32'h20994400, 3, 8'h00, 2, 1, 1'b1, 17'h1ABCE, 8'h99, 1'b0, 8'h00, 0, 0};

        reset = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_rx = 1'b0; bus_rd_data = 8'h00;
        repeat (3) @(negedge clk);
        check_outputs_reset("rst0");
        reset = 1'b0;
        repeat (5) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            bus_rd_data = vecs[v].rd_data;
            ack_lat = vecs[v].lat;
            n0 = log_addr.size(); e0 = err_cnt; l0 = late_cnt; r0 = req_rise;
            spi_frame(vecs[v].bytes, vecs[v].nbytes, miso);
            repeat (20) @(negedge clk);
            check($sformatf("v%0d_nreq", v), log_addr.size() - n0, vecs[v].exp_reqs);
            check($sformatf("v%0d_nrise", v), req_rise - r0, vecs[v].exp_reqs);
            if (vecs[v].exp_reqs > 0 && log_addr.size() > n0) begin
                check($sformatf("v%0d_we", v), log_we[$], vecs[v].exp_we);
                check($sformatf("v%0d_addr", v), log_addr[$], vecs[v].exp_addr);
                if (vecs[v].exp_we) check($sformatf("v%0d_wdata", v), log_data[$], vecs[v].exp_wdata);
            end
            if (vecs[v].chk_miso) check($sformatf("v%0d_miso", v), miso, vecs[v].exp_miso);
            check($sformatf("v%0d_cmd_err", v), err_cnt - e0, vecs[v].exp_err);
            check($sformatf("v%0d_rd_late", v), late_cnt - l0, vecs[v].exp_late);
        end

        // Late read, then a second late read proving stale rd_valid is cleared.
        for (int k = 0; k < 2; k++) begin
            ack_en = 1'b0; ack_lat = 1; bus_rd_data = 8'h5E;
            n0 = log_addr.size(); l0 = late_cnt;
            spi_frame(32'h30000000, 2, miso);
            check($sformatf("late%0d_miso", k), miso, 8'h00);
            check($sformatf("late%0d_pulse", k), late_cnt - l0, 1);
            check($sformatf("late%0d_req_pending", k), bus_req, 1);
            ack_en = 1'b1;
            repeat (20) @(negedge clk);
            check($sformatf("late%0d_nreq", k), log_addr.size() - n0, 1);
            check($sformatf("late%0d_bus_req", k), bus_req, 0);
            if (log_addr.size() > n0) begin
                check($sformatf("late%0d_addr", k), log_addr[$], (k == 0) ? 17'h1ABCF : 17'h1ABD0);
                check($sformatf("late%0d_we", k), log_we[$], 0);
            end
        end

        // Queue: second request queued, third overwrites it.
        ack_en = 1'b0; n0 = log_addr.size(); r0 = req_rise;
        spi_frame(32'h20110000, 2, miso);
        spi_frame(32'h20220000, 2, miso);
        spi_frame(32'h20330000, 2, miso);
        ack_en = 1'b1; ack_lat = 1;
        repeat (30) @(negedge clk);
        check("q_nreq", log_addr.size() - n0, 2);
        check("q_nrise", req_rise - r0, 2);
        if (log_addr.size() >= n0 + 2) begin
            check("q0_addr", log_addr[n0], 17'h1ABD1);
            check("q0_data", log_data[n0], 8'h11);
            check("q1_addr", log_addr[n0+1], 17'h1ABD3);
            check("q1_data", log_data[n0+1], 8'h33);
        end

        // Pending write, partial WRITE_AT (13 bits), then reset.
        ack_en = 1'b0; r0 = req_rise;
        spi_frame(32'h20660000, 2, miso);
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        spi_byte(8'h01, b8);
        for (int i = 7; i >= 3; i--) spi_bit(1'b1, bt);
        spi_cs_n = 1'b1;
        repeat (20) @(negedge clk);
        check("partial_nrise", req_rise - r0, 1);
        check("partial_req_pending", bus_req, 1);
        reset = 1'b1;
        @(negedge clk);
        check_outputs_reset("rst1");
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("post_rst_idle", bus_req, 0);
        ack_en = 1'b1; ack_lat = 2; n0 = log_addr.size();
        spi_frame(32'h20550000, 2, miso);
        repeat (20) @(negedge clk);
        check("post_rst_nreq", log_addr.size() - n0, 1);
        if (log_addr.size() > n0) begin
            check("post_rst_addr", log_addr[$], 17'h00001);
            check("post_rst_data", log_data[$], 8'h55);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
